// File: rtl/instr_sequencer_if.sv
// Program-side bus between the loader/controller and instr_sequencer.
// Carries store writes, run control and the issued instruction stream.
interface instr_sequencer_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
);
  logic                   load_en;
  logic [PC_BITS-1:0]     load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   start;
  logic                   stop;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   done;

  modport master (
    output load_en, load_addr, load_data, start, stop,
    input  instruction, instr_valid, pc, busy, done
  );

  modport slave (
    input  load_en, load_addr, load_data, start, stop,
    output instruction, instr_valid, pc, busy, done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction store plus PC that issues each word to simple_cpu
// for a class-dependent number of cycles, stopping at an all-zero word.
module instr_sequencer #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int ALU_HOLD    = 3,
  parameter int MEM_HOLD    = 3
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE
  } state_t;

  localparam int                 DEPTH   = 2 ** PC_BITS;
  localparam logic [PC_BITS-1:0] PC_MAX  = '1;
  localparam logic [3:0]         ALU_CNT = 4'(ALU_HOLD - 1);
  localparam logic [3:0]         MEM_CNT = 4'(MEM_HOLD - 1);

  state_t                 state_q, state_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [3:0]             hold_cnt;
  logic [INSTR_WIDTH-1:0] word;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  assign word = mem[pc_q];

  // Store write port, only open while idle
  always_ff @(posedge clk) begin
    if (bus.load_en && state_q == IDLE)
      mem[bus.load_addr] <= bus.load_data;
  end

  // Hold length (minus one) from the word's class bits
  always_comb begin
    hold_cnt = '0;
    unique case (word[INSTR_WIDTH-1:INSTR_WIDTH-2])
      2'b01:        hold_cnt = ALU_CNT;
      2'b10, 2'b11: hold_cnt = MEM_CNT;
      default:      hold_cnt = '0;
    endcase
  end

  // State, pc, issued word and hold counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: stop wins over counter expiry; HALT never reaches the bus
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.stop) begin
          instr_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (word == '0) begin
          instr_d = '0;
          state_d = DONE;
        end else begin
          instr_d = word;
          cnt_d   = hold_cnt;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.stop) begin
          instr_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pc_q == PC_MAX) begin
          instr_d = '0;
          state_d = DONE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = (state_q == ISSUE);
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);

endmodule
